// File: rtl/argmax_seq_ctrl.sv
// Collects one frame of N_CLS signed logits, runs an external argmax unit over them, and returns the class.
// Optional argmax watchdog: define ARGMAX_SEQ_TIMEOUT_EN to enable it.
module argmax_seq_ctrl #(
  parameter int DATA_W  = 64,
  parameter int N_CLS   = 10,
  parameter int TMO_CYC = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic signed [DATA_W-1:0]  s_data,
  input  logic                      s_last,
  output logic                      am_resetn,
  output logic                      am_start,
  output logic [N_CLS*DATA_W-1:0]   am_data,
  input  logic                      am_done,
  input  logic [3:0]                am_index,
  output logic                      r_valid,
  input  logic                      r_ready,
  output logic [3:0]                r_class,
  output logic                      r_err,
  output logic [15:0]               img_count,
  output logic                      busy
);

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_CLEAR,
    ST_LAUNCH,
    ST_WAIT,
    ST_OUT
  } state_t;

  localparam logic [3:0] LAST_PTR = 4'(N_CLS - 1);

  state_t             state_q;
  logic [3:0]         wr_ptr_q;
  logic               s_ready_q;
  logic               am_resetn_q;
  logic               am_start_q;
  logic               r_valid_q;
  logic [3:0]         r_class_q;
  logic               r_err_q;
  logic               frame_err_q;
  logic [15:0]        img_count_q;
  logic [15:0]        img_count_d;
  logic               busy_q;
  logic               accept;
  logic               tmo_hit;
  logic signed [DATA_W-1:0] buf_q [N_CLS];

  assign accept      = (state_q == ST_COLLECT) && s_valid && s_ready_q;
  assign img_count_d = img_count_q + 16'd1;

`ifdef ARGMAX_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_q;
  logic [TMO_W-1:0] tmo_cnt_d;

  assign tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
  // am_done has priority over an expiring watchdog in the same cycle
  assign tmo_hit   = (state_q == ST_WAIT) && !am_done && (tmo_cnt_d == TMO_W'(TMO_CYC));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ST_LAUNCH) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ST_WAIT) begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < N_CLS; k++) buf_q[k] <= '0;
    end else if (accept) begin
      buf_q[wr_ptr_q] <= s_data;
    end
  end

  for (genvar k = 0; k < N_CLS; k++) begin : g_pack
    assign am_data[k*DATA_W +: DATA_W] = buf_q[k];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_COLLECT;
      wr_ptr_q    <= '0;
      s_ready_q   <= 1'b0;
      am_resetn_q <= 1'b0;
      am_start_q  <= 1'b0;
      r_valid_q   <= 1'b0;
      r_class_q   <= '0;
      r_err_q     <= 1'b0;
      frame_err_q <= 1'b0;
      img_count_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      am_resetn_q <= 1'b1;
      am_start_q  <= 1'b0;
      unique case (state_q)
        ST_COLLECT: begin
          s_ready_q <= 1'b1;
          if (accept) begin
            busy_q <= 1'b1;
            if (wr_ptr_q == LAST_PTR) begin
              state_q     <= ST_CLEAR;
              s_ready_q   <= 1'b0;
              am_resetn_q <= 1'b0;
              frame_err_q <= !s_last;
            end else if (s_last) begin
              // short frame: report an error without running the argmax unit
              state_q   <= ST_OUT;
              s_ready_q <= 1'b0;
              r_valid_q <= 1'b1;
              r_class_q <= 4'h0;
              r_err_q   <= 1'b1;
            end else begin
              wr_ptr_q <= wr_ptr_q + 4'd1;
            end
          end
        end
        ST_CLEAR: begin
          state_q    <= ST_LAUNCH;
          am_start_q <= 1'b1;
        end
        ST_LAUNCH: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (am_done) begin
            state_q   <= ST_OUT;
            r_valid_q <= 1'b1;
            r_class_q <= am_index;
            r_err_q   <= frame_err_q;
          end else if (tmo_hit) begin
            state_q   <= ST_OUT;
            r_valid_q <= 1'b1;
            r_class_q <= 4'hF;
            r_err_q   <= 1'b1;
          end
        end
        ST_OUT: begin
          if (r_ready) begin
            state_q     <= ST_COLLECT;
            r_valid_q   <= 1'b0;
            wr_ptr_q    <= '0;
            img_count_q <= img_count_d;
            s_ready_q   <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= ST_COLLECT;
      endcase
    end
  end

  assign s_ready   = s_ready_q;
  assign am_resetn = am_resetn_q;
  assign am_start  = am_start_q;
  assign r_valid   = r_valid_q;
  assign r_class   = r_class_q;
  assign r_err     = r_err_q;
  assign img_count = img_count_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_argmax_seq_ctrl.sv
// Scoreboard bench for argmax_seq_ctrl with a behavioural argmax unit model.
module tb_argmax_seq_ctrl;
  localparam int DW  = 64;
  localparam int NC  = 10;
  localparam int TMO = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  resetn;
  logic                  s_valid;
  logic                  s_ready;
  logic signed [DW-1:0]  s_data;
  logic                  s_last;
  logic                  am_resetn;
  logic                  am_start;
  logic [NC*DW-1:0]      am_data;
  logic                  am_done;
  logic [3:0]            am_index;
  logic                  r_valid;
  logic                  r_ready;
  logic [3:0]            r_class;
  logic                  r_err;
  logic [15:0]           img_count;
  logic                  busy;

  argmax_seq_ctrl #(.DATA_W(DW), .N_CLS(NC), .TMO_CYC(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .am_resetn(am_resetn), .am_start(am_start), .am_data(am_data),
    .am_done(am_done), .am_index(am_index),
    .r_valid(r_valid), .r_ready(r_ready), .r_class(r_class), .r_err(r_err),
    .img_count(img_count), .busy(busy)
  );

  typedef struct packed {
    logic [3:0]  cls;
    logic        err;
    logic [15:0] img;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int am_lat   = 1;
  int am_en    = 1;
  int n_clr    = 0;
  int n_start  = 0;
  int start_cyc = 0;
  int rv_cyc   = 0;
  int acc_cyc  = 0;
  logic rv_seen = 1'b0;
  logic [15:0] exp_img = '0;
  logic signed [DW-1:0] cur_vec [NC];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] argmax_model(input logic [NC*DW-1:0] d);
    logic signed [DW-1:0] best;
    logic [3:0] idx;
    best = d[DW-1:0];
    idx  = 4'd0;
    for (int k = 1; k < NC; k++) begin
      if ($signed(d[k*DW +: DW]) > best) begin
        best = d[k*DW +: DW];
        idx  = 4'(k);
      end
    end
    return idx;
  endfunction

  // Behavioural argmax unit: am_done pulses am_lat cycles after am_start
  initial begin : am_model
    int pend;
    logic [3:0] idx;
    pend = 0;
    idx = '0;
    am_done = 1'b0;
    am_index = '0;
    forever begin
      @(posedge clk);
      #1;
      am_done = 1'b0;
      if (!resetn || !am_resetn) begin
        pend = 0;
      end else if (am_start && am_en != 0) begin
        pend = am_lat;
        idx  = argmax_model(am_data);
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          am_done  = 1'b1;
          am_index = idx;
        end
      end
    end
  end

  // Scoreboard monitor: pops on every result handshake
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && r_valid && r_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: r_class=%0h r_err=%0b, none required", r_class, r_err);
        end else begin
          e = sb.pop_front();
          check("r_class", r_class, e.cls);
          check("r_err", r_err, e.err);
          check("img_count_at_hs", img_count, e.img);
        end
      end
    end
  end

  initial begin : ctrl_watch
    logic prev_amrn;
    logic rv_prev;
    prev_amrn = 1'b0;
    rv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (!am_resetn) n_clr++;
        if (am_start) begin
          n_start++;
          start_cyc = cyc;
          check("clear_before_start", prev_amrn, 1'b0);
        end
        if (r_valid && !rv_prev) begin
          rv_cyc  = cyc;
          rv_seen = 1'b1;
        end
      end
      prev_amrn = am_resetn;
      rv_prev   = r_valid;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input logic [3:0] c, input logic e);
    exp_t x;
    x.cls = c;
    x.err = e;
    x.img = exp_img;
    sb.push_back(x);
    exp_img++;
  endtask

  task automatic send_frame(input int n, input int last_at);
    int t;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = cur_vec[i];
      s_last  = (i + 1 == last_at);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!s_ready && t < 100);
      if (!s_ready) check("beat_accept_timeout", s_ready, 1'b1);
      acc_cyc = cyc;
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (sb.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin : stim
    int t;
    int a_cyc;
    logic stable;
    logic sr_bad;
    resetn = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    r_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_am_resetn", am_resetn, 1'b0);
    check("rst_am_start", am_start, 1'b0);
    check("rst_r_valid", r_valid, 1'b0);
    check("rst_r_class", r_class, 4'h0);
    check("rst_r_err", r_err, 1'b0);
    check("rst_img_count", img_count, 16'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_am_data", |am_data, 1'b0);
    tick();
    resetn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("s_ready_after_reset", s_ready, 1'b1);
    tick();

    // Nominal frame, argmax at index 2
    cur_vec = '{5, -3, 9, 2, 0, 1, 7, 8, -1, 4};
    am_lat = 1;
    n_clr = 0;
    n_start = 0;
    expect_res(4'd2, 1'b0);
    send_frame(10, 10);
    a_cyc = acc_cyc;
    wait_drain(100);
    check("latency_accept_to_rvalid", 64'(rv_cyc - a_cyc), 64'd4);
    check("t1_img_count", img_count, 16'd1);
    check("t1_n_start", n_start, 1);
    check("t1_n_clear", n_clr, 1);
    check("t1_busy_idle", busy, 1'b0);
    check("t1_s_ready_idle", s_ready, 1'b1);
    check("am_data_entry2", am_data[2*DW +: DW], 64'd9);
    check("am_data_entry1", am_data[1*DW +: DW], 64'hFFFF_FFFF_FFFF_FFFD);
    tick();

    // Short frame: s_last on beat 4
    cur_vec = '{11, 22, 33, 44, 0, 0, 0, 0, 0, 0};
    n_clr = 0;
    n_start = 0;
    expect_res(4'd0, 1'b1);
    send_frame(4, 4);
    wait_drain(100);
    check("t2_n_start", n_start, 0);
    check("t2_n_clear", n_clr, 0);
    check("t2_img_count", img_count, 16'd2);
    tick();

    // Ten beats without s_last: result delivered with frame error
    cur_vec = '{-7, -2, -9, -5, -3, -8, -4, -6, -1, -10};
    am_lat = 2;
    n_start = 0;
    expect_res(4'd8, 1'b1);
    send_frame(10, 0);
    wait_drain(100);
    check("t3_n_start", n_start, 1);
    check("t3_img_count", img_count, 16'd3);
    tick();

    // Result back-pressure for 20 cycles
    cur_vec = '{1, 2, 3, 100, 5, 6, 7, 8, 9, 50};
    am_lat = 3;
    r_ready = 1'b0;
    expect_res(4'd3, 1'b0);
    send_frame(10, 10);
    t = 0;
    while (!r_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("t4_r_valid_up", r_valid, 1'b1);
    stable = 1'b1;
    sr_bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (r_valid !== 1'b1 || r_class !== 4'd3 || r_err !== 1'b0) stable = 1'b0;
      if (s_ready !== 1'b0) sr_bad = 1'b1;
    end
    check("t4_result_stable", stable, 1'b1);
    check("t4_s_ready_low_while_held", sr_bad, 1'b0);
    tick();
    r_ready = 1'b1;
    @(negedge clk);
    check("t4_s_ready_hs_cycle", s_ready, 1'b0);
    @(negedge clk);
    check("t4_accept_after_hs", s_ready, 1'b1);
    check("t4_r_valid_fall", r_valid, 1'b0);
    check("t4_img_count", img_count, 16'd4);
    tick();

    // Reset pulse during WAIT discards the result
    cur_vec = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    am_lat = 10;
    n_start = 0;
    send_frame(10, 10);
    t = 0;
    while (n_start == 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("t5_started", n_start, 1);
    tick();
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    rv_seen = 1'b0;
    repeat (30) @(negedge clk);
    check("t5_no_r_valid", rv_seen, 1'b0);
    check("t5_img_count_cleared", img_count, 16'd0);
    exp_img = '0;
    tick();
    cur_vec = '{5, -3, 9, 2, 0, 1, 7, 8, -1, 4};
    am_lat = 2;
    expect_res(4'd2, 1'b0);
    send_frame(10, 10);
    wait_drain(100);
    check("t5_img_count_after", img_count, 16'd1);
    tick();

`ifdef ARGMAX_SEQ_TIMEOUT_EN
    // Watchdog: argmax unit never answers
    cur_vec = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
    am_en = 0;
    expect_res(4'hF, 1'b1);
    send_frame(10, 10);
    wait_drain(200);
    check("tmo_latency", 64'(rv_cyc - start_cyc), 64'(TMO + 1));
    check("tmo_img_count", img_count, 16'd2);
    am_en = 1;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
